fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface: owns the program counter, drives the word address into the combinational instruction ROM and captures the returned word into the IF/ID pipeline register.
- Computes next-PC for sequential, branch, j/jal and jr flow with one MIPS delay slot.
- Honours stall and flush from the hazard unit.
- Sits between the hazard/branch logic in ID and the instruction ROM.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit_npc_calc.sv | 42 ++++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch reset/NOP values, next-PC select encodings,
// and exception codes used by the fetch stage and later pipeline stages.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  // Next-PC source select driven by the ID-stage decoder
  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // Address-error-on-load/fetch cause code, reserved for exception handling
  localparam logic [4:0] EXC_ADEL = 5'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the
// zero-latency instruction ROM (slave).
//   im_pc    : word fetch address, driven by the master
//   im_instr : ROM data for im_pc, valid in the same cycle
interface fetch_unit_if;

  logic [31:0] im_pc;
  logic [31:0] im_instr;

  modport master (output im_pc, input im_instr);
  modport slave  (input im_pc, output im_instr);

endinterface

// File: rtl/fetch_unit_npc_calc.sv
// npc_calc: purely combinational next-PC selection for sequential flow,
// conditional branch, j/jal and jr.
//   pc          : current fetch PC
//   npc_sel     : NPC_SEQ / NPC_BR / NPC_J / NPC_JR
//   br_taken    : branch outcome, only meaningful for NPC_BR
//   id_pc       : PC of the control-transfer instruction in ID
//   imm16       : branch word offset
//   instr_index : jump word index
//   jr_target   : forwarded rs value
//   npc_c       : selected next PC (combinational)
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] id_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] npc_c
);

  logic [31:0] pc_plus4;
  logic [31:0] id_pc_plus4;
  logic [31:0] br_off;

  // Branch/jump targets are relative to the delay-slot address id_pc + 4
  always_comb begin
    pc_plus4    = pc + 32'd4;
    id_pc_plus4 = id_pc + 32'd4;
    br_off      = {{14{imm16[15]}}, imm16, 2'b00};
    npc_c       = pc_plus4;
    case (npc_sel)
      NPC_SEQ: npc_c = pc_plus4;
      NPC_BR:  if (br_taken) npc_c = id_pc_plus4 + br_off;
      NPC_J:   npc_c = {id_pc_plus4[31:28], instr_index, 2'b00};
      NPC_JR:  npc_c = jr_target;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives the instruction ROM and captures the
// returned word into the IF/ID register. Priority: reset > flush > stall.
// Optional macro FETCH_ADDR_CHECK_EN adds a fetch-address fault check and
// the if_id_exc output.
//   clk, reset        : clock, synchronous active-high reset
//   stall, flush      : hazard-unit controls
//   npc_sel, br_taken, id_pc, imm16, instr_index, jr_target : redirect info from ID
//   im                : ROM bus (im_pc out, im_instr in)
//   if_id_instr/pc/pc8: IF/ID register outputs
//   if_id_exc         : fetch address fault (FETCH_ADDR_CHECK_EN only)
module fetch_unit #(
  parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
`ifdef FETCH_ADDR_CHECK_EN
  parameter int unsigned IM_WORDS = 4096,
`endif
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic [1:0]          npc_sel,
  input  logic                br_taken,
  input  logic [31:0]         id_pc,
  input  logic [15:0]         imm16,
  input  logic [25:0]         instr_index,
  input  logic [31:0]         jr_target,
  fetch_unit_if.master        im,
  output logic [31:0]         if_id_instr,
  output logic [31:0]         if_id_pc,
  output logic [31:0]         if_id_pc8
`ifdef FETCH_ADDR_CHECK_EN
  ,
  output logic                if_id_exc
`endif
);

  logic [31:0] pc;
  logic [31:0] npc_c;

  assign im.im_pc = pc;

  npc_calc u_npc_calc (
    .pc          (pc),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .id_pc       (id_pc),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .npc_c       (npc_c)
  );

`ifdef FETCH_ADDR_CHECK_EN
  // 33-bit end bound so a ROM ending at 2^32 does not wrap the compare
  localparam logic [32:0] IM_END = {1'b0, PC_RESET} + 33'(IM_WORDS) * 33'd4;

  logic fault_c;
  assign fault_c = (pc[1:0] != 2'b00) || (pc < PC_RESET) || ({1'b0, pc} >= IM_END);
`endif

  // PC and IF/ID register; a redirect is dropped on stall since ID repeats
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      if_id_instr <= NOP_WORD;
      if_id_pc    <= PC_RESET;
      if_id_pc8   <= PC_RESET + 32'd8;
`ifdef FETCH_ADDR_CHECK_EN
      if_id_exc   <= 1'b0;
`endif
    end else if (flush) begin
      pc          <= npc_c;
      if_id_instr <= NOP_WORD;
      if_id_pc    <= pc;
      if_id_pc8   <= pc + 32'd8;
`ifdef FETCH_ADDR_CHECK_EN
      if_id_exc   <= 1'b0;
`endif
    end else if (!stall) begin
      pc          <= npc_c;
      if_id_pc    <= pc;
      if_id_pc8   <= pc + 32'd8;
`ifdef FETCH_ADDR_CHECK_EN
      if_id_exc   <= fault_c;
      if_id_instr <= fault_c ? NOP_WORD : im.im_instr;
`else
      if_id_instr <= im.im_instr;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset-override
// sequence, then randomized traffic against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] BASE = 32'h0000_3000;
  localparam logic [31:0] LIMIT = 32'h0000_7000;

  logic        clk = 1'b0;
  logic        reset, stall, flush, br_taken;
  logic [1:0]  npc_sel;
  logic [31:0] id_pc, jr_target;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc8;
  logic        if_id_exc;

  int checks   = 0;
  int failures = 0;

  fetch_unit_if imif ();

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign imif.im_instr = rom_word(imif.im_pc);

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .id_pc       (id_pc),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .im          (imif),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc8   (if_id_pc8)
`ifdef FETCH_ADDR_CHECK_EN
    ,
    .if_id_exc   (if_id_exc)
`endif
  );

`ifndef FETCH_ADDR_CHECK_EN
  assign if_id_exc = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                         input logic [31:0] e_instr, input logic e_exc);
    chk({tag, ".im_pc"},       imif.im_pc,  e_pc);
    chk({tag, ".if_id_pc"},    if_id_pc,    e_ifpc);
    chk({tag, ".if_id_instr"}, if_id_instr, e_instr);
    chk({tag, ".if_id_pc8"},   if_id_pc8,   e_ifpc + 32'd8);
`ifdef FETCH_ADDR_CHECK_EN
    chk({tag, ".if_id_exc"},   32'(if_id_exc), 32'(e_exc));
`else
    if (e_exc) begin end
`endif
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic [1:0] sel,
                       input logic br, input logic [31:0] ipc, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] jr);
    reset = r; stall = s; flush = f; npc_sel = sel; br_taken = br;
    id_pc = ipc; imm16 = imm; instr_index = idx; jr_target = jr;
  endtask

  typedef struct {
    logic        stall, flush;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] id_pc;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] jr;
    logic [31:0] e_pc, e_ifpc;
    logic        e_nop, e_exc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic [1:0] sel, input logic br,
                              input logic [31:0] ipc, input logic [15:0] imm, input logic [25:0] idx,
                              input logic [31:0] jr, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                              input logic e_nop, input logic e_exc);
    vec_t v;
    v.stall = s; v.flush = f; v.sel = sel; v.br = br; v.id_pc = ipc; v.imm = imm; v.idx = idx;
    v.jr = jr; v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_nop = e_nop; v.e_exc = e_exc;
    return v;
  endfunction

  // Behavioural reference state
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_exc;

  function automatic logic addr_fault(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a % 4 != 0) || (a < BASE) || (a >= LIMIT);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic model_step();
    logic [31:0] target;
    logic        f;
    case (npc_sel)
      2'd1:    target = br_taken ? id_pc + 32'd4 + 32'(int'($signed(imm16)) * 4) : m_pc + 32'd4;
      2'd2:    target = ((id_pc + 32'd4) & 32'hF000_0000) | (32'(instr_index) * 4);
      2'd3:    target = jr_target;
      default: target = m_pc + 32'd4;
    endcase
    if (reset) begin
      m_pc = BASE; m_instr = NOP; m_ifpc = BASE; m_exc = 1'b0;
    end else if (flush) begin
      m_instr = NOP; m_ifpc = m_pc; m_exc = 1'b0; m_pc = target;
    end else if (!stall) begin
      f = addr_fault(m_pc);
      m_instr = f ? NOP : rom_word(m_pc);
      m_ifpc = m_pc; m_exc = f; m_pc = target;
    end
  endtask

  vec_t vecs[23];

  initial begin
    logic [31:0] e_instr;
    logic        use_nop;

    vecs[0]  = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h3004, 32'h3000, 0,0);
    vecs[1]  = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h3008, 32'h3004, 0,0);
    vecs[2]  = mk(0,0,2'd1,1, 32'h3004, 16'hFFFF, 26'h0,     32'h0,         32'h3004, 32'h3008, 0,0);
    vecs[3]  = mk(0,0,2'd1,0, 32'h3000, 16'h0010, 26'h0,     32'h0,         32'h3008, 32'h3004, 0,0);
    vecs[4]  = mk(0,0,2'd2,0, 32'h3010, 16'h0,    26'h0C10,  32'h0,         32'h3040, 32'h3008, 0,0);
    vecs[5]  = mk(0,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h3100,      32'h3100, 32'h3040, 0,0);
    vecs[6]  = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h3104, 32'h3100, 0,0);
    vecs[7]  = mk(0,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h300C,      32'h300C, 32'h3104, 0,0);
    vecs[8]  = mk(1,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h300C, 32'h3104, 0,0);
    vecs[9]  = mk(1,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h300C, 32'h3104, 0,0);
    vecs[10] = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h3010, 32'h300C, 0,0);
    vecs[11] = mk(1,1,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h3014, 32'h3010, 1,0);
    vecs[12] = mk(0,1,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h3200,      32'h3200, 32'h3014, 1,0);
    vecs[13] = mk(1,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h5000,      32'h3200, 32'h3014, 1,0);
    vecs[14] = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h3204, 32'h3200, 0,0);
    vecs[15] = mk(0,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3204, 0,0);
    vecs[16] = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 0,1);
    vecs[17] = mk(0,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h3102,      32'h3102, 32'h0000_0000, 0,1);
    vecs[18] = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h3106, 32'h3102, 0,1);
    vecs[19] = mk(0,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h2FFC,      32'h2FFC, 32'h3106, 0,1);
    vecs[20] = mk(0,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h7000,      32'h7000, 32'h2FFC, 0,1);
    vecs[21] = mk(0,0,2'd3,0, 32'h0,    16'h0,    26'h0,     32'h6FFC,      32'h6FFC, 32'h7000, 0,1);
    vecs[22] = mk(0,0,2'd0,0, 32'h0,    16'h0,    26'h0,     32'h0,         32'h7000, 32'h6FFC, 0,0);

    // Reset and check reset state
    drive(1,0,0,2'd0,0,32'h0,16'h0,26'h0,32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", BASE, BASE, NOP, 1'b0);

    // Directed vector table
    for (int i = 0; i < 23; i++) begin
      drive(0, vecs[i].stall, vecs[i].flush, vecs[i].sel, vecs[i].br,
            vecs[i].id_pc, vecs[i].imm, vecs[i].idx, vecs[i].jr);
      @(posedge clk);
      #1;
      use_nop = vecs[i].e_nop;
`ifdef FETCH_ADDR_CHECK_EN
      use_nop = use_nop | vecs[i].e_exc;
      e_instr = use_nop ? NOP : rom_word(vecs[i].e_ifpc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, e_instr, vecs[i].e_exc);
`else
      e_instr = use_nop ? NOP : rom_word(vecs[i].e_ifpc);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, e_instr, 1'b0);
`endif
    end

    // Reset asserted together with stall and flush overrides both
    drive(1,1,1,2'd3,0,32'h0,16'h0,26'h0,32'h5550);
    @(posedge clk);
    #1;
    chk_all("reset_over_stall_flush", BASE, BASE, NOP, 1'b0);

    // Randomized traffic against the behavioural model
    m_pc = BASE; m_instr = NOP; m_ifpc = BASE; m_exc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            BASE + 32'($urandom_range(0, 1023)) * 4,
            16'($urandom),
            26'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'($urandom) : BASE + 32'($urandom_range(0, 4095)) * 4);
      model_step();
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", c), m_pc, m_ifpc, m_instr, m_exc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
